// File: rtl/gyruss_audio_mixer.sv
// Time-multiplexed Gyruss sound mixer: per-sample snapshot of NCH channel levels,
// serial gain/accumulate through one multiplier, saturation, held 16-bit output.
module gyruss_audio_mixer #(
  parameter int NCH = 5,
  parameter int DIV = 220
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*10-1:0] ch_in,
  input  logic [NCH*8-1:0]  gain,
  input  logic              mute,
  input  logic              clip_clr,
  output logic [15:0]       out,
  output logic              out_valid,
  output logic              clip
);

  // state | meaning
  // IDLE  | waiting for divider tick; snapshots inputs on tick
  // ACC   | one channel per cycle multiplied and accumulated
  // SAT   | shift, saturate (or mute) and present the sample

  localparam int CW = $clog2(DIV);

  generate
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("gyruss_audio_mixer: NCH must be 1..8");
    end
    if (DIV < NCH + 3) begin : g_bad_div
      $error("gyruss_audio_mixer: DIV must be at least NCH+3");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t             state;
  logic [CW-1:0]      div_cnt;
  logic               tick;
  logic [9:0]         ch_snap   [NCH];
  logic [7:0]         gain_snap [NCH];
  logic               mute_snap;
  logic [2:0]         idx;
  logic signed [21:0] acc;

  logic signed [10:0] s;
  logic signed [19:0] p;
  logic signed [21:0] r;
  logic               pos_sat;
  logic               neg_sat;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_comb begin
    s       = $signed({1'b0, ch_snap[idx]}) - 11'sd512;
    p       = s * $signed({1'b0, gain_snap[idx]});
    r       = acc >>> 3;
    pos_sat = (r > 22'sd32767);
    neg_sat = (r < -22'sd32768);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      acc       <= '0;
      idx       <= '0;
      mute_snap <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ch_snap[i]   <= '0;
        gain_snap[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      if (clip_clr) clip <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < NCH; i++) begin
              ch_snap[i]   <= ch_in[10*i +: 10];
              gain_snap[i] <= gain[8*i +: 8];
            end
            mute_snap <= mute;
            acc       <= '0;
            idx       <= '0;
            state     <= ACC;
          end
        end
        ACC: begin
          acc <= acc + 22'(p);
          if (idx == 3'(NCH - 1)) state <= SAT;
          else                    idx   <= idx + 3'd1;
        end
        SAT: begin
          out_valid <= 1'b1;
          state     <= IDLE;
          // a saturation here overrides a clip_clr seen in the same cycle
          if (mute_snap) begin
            out <= '0;
          end else if (pos_sat) begin
            out  <= 16'h7fff;
            clip <= 1'b1;
          end else if (neg_sat) begin
            out  <= 16'h8000;
            clip <= 1'b1;
          end else begin
            out <= r[15:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
